// File: rtl/lc3_mem_access_unit.sv
// lc3_mem_access_unit: sequences LD/LDI/ST memory transactions and register write-back from a decoded control word
module lc3_mem_access_unit #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        alu_op,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              reg_write,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [DATA_W-1:0] alu_result,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              done,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, RD1, RD2, WR, FIN} state_t;
  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ind;
  logic             is_ld, is_ldi, is_st, is_reg, to_hit;
  always_comb begin
    is_ld  = alu_op == 4'b0011 && mem_read && !mem_write;
    is_ldi = alu_op == 4'b0100 && mem_read && !mem_write;
    is_st  = alu_op == 4'b0110 && mem_write && !mem_read;
    is_reg = (alu_op == 4'b0000 || alu_op == 4'b0001 || alu_op == 4'b0010 || alu_op == 4'b0101)
             && reg_write && !mem_read && !mem_write;
    to_hit = TIMEOUT != 0 && cnt + CNT_W'(1) == TO;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ind       <= 1'b0;
      req_ready <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      rf_we     <= 1'b0;
      rf_wdata  <= '0;
      err       <= 1'b0;
    end else begin
      done  <= 1'b0;
      rf_we <= 1'b0;
      err   <= 1'b0;
      unique case (state)
        IDLE: if (req_valid) begin
          req_ready <= 1'b0;
          cnt       <= '0;
          ind       <= is_ldi;
          if (is_ld || is_ldi || is_st) begin
            state    <= is_st ? WR : RD1;
            mem_req  <= 1'b1;
            mem_we   <= is_st;
            mem_addr <= addr;
            if (is_st) mem_wdata <= st_data;
          end else begin
            state <= FIN;
            done  <= 1'b1;
            rf_we <= is_reg;
            err   <= !is_reg;
            if (is_reg) rf_wdata <= alu_result;
          end
        end
        RD1, RD2, WR: if (mem_ready) begin
          cnt <= '0;
          if (state == RD1 && ind) begin
            state    <= RD2;
            mem_addr <= mem_rdata;
          end else begin
            state   <= FIN;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            rf_we   <= state != WR;
            if (state != WR) rf_wdata <= mem_rdata;
          end
        end else if (to_hit) begin
          state   <= FIN;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          done    <= 1'b1;
          err     <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        FIN: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lc3_mem_access_unit.sv
// tb_lc3_mem_access_unit: directed checks of load, indirect load, store, timeout, pass-through and reset
module tb_lc3_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, mem_read, mem_write, reg_write;
  logic [3:0]  alu_op;
  logic [15:0] addr, st_data, alu_result, mem_addr, mem_wdata, mem_rdata, rf_wdata;
  logic        mem_req, mem_we, mem_ready, done, rf_we, err;
  int          tests = 0, fails = 0;

  lc3_mem_access_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .addr(addr), .st_data(st_data), .alu_result(alu_result),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .done(done), .rf_we(rf_we),
    .rf_wdata(rf_wdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [3:0] op, input logic rd, input logic wr, input logic rw,
                        input logic [15:0] a, input logic [15:0] sd, input logic [15:0] ar);
    alu_op = op; mem_read = rd; mem_write = wr; reg_write = rw;
    addr = a; st_data = sd; alu_result = ar; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; alu_op = '0; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
    addr = '0; st_data = '0; alu_result = '0; mem_rdata = '0; mem_ready = 1'b0;
    tick(); tick();
    check("rst_ready", req_ready, 1);
    check("rst_req", mem_req, 0);
    check("rst_outs", {done, rf_we, err, mem_we}, 0);
    check("rst_data", {mem_addr, rf_wdata}, 0);
    check("rst_wdata", mem_wdata, 0);
    rst = 1'b0;
    tick();

    // LD zero-wait
    mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    accept(4'b0011, 1, 0, 1, 16'h3000, 16'h0, 16'h0);
    check("ld_req", {mem_req, mem_we, done}, 3'b100);
    check("ld_addr", mem_addr, 16'h3000);
    check("ld_busy", req_ready, 0);
    tick();
    check("ld_done", {done, rf_we, err, mem_req}, 4'b1100);
    check("ld_data", rf_wdata, 16'hBEEF);
    tick();
    check("ld_idle", {done, req_ready}, 2'b01);

    // LDI with two wait states per read
    mem_ready = 1'b0;
    accept(4'b0100, 1, 0, 1, 16'h4000, 16'h0, 16'h0);
    check("ldi_addr1", mem_addr, 16'h4000);
    tick(); tick();
    check("ldi_wait1", {mem_req, done}, 2'b10);
    mem_ready = 1'b1; mem_rdata = 16'h5123;
    tick();
    mem_ready = 1'b0; mem_rdata = 16'h0;
    check("ldi_chain_req", {mem_req, mem_we, done}, 3'b100);
    check("ldi_addr2", mem_addr, 16'h5123);
    tick(); tick();
    check("ldi_wait2", {mem_req, done}, 2'b10);
    mem_ready = 1'b1; mem_rdata = 16'h00A5;
    tick();
    check("ldi_done", {done, rf_we, err}, 3'b110);
    check("ldi_data", rf_wdata, 16'h00A5);
    tick();

    // ST with 3 wait cycles, later input changes ignored
    mem_ready = 1'b0;
    accept(4'b0110, 0, 1, 0, 16'h6000, 16'h1234, 16'h0);
    st_data = 16'hFFFF; addr = 16'h0;
    for (int i = 0; i < 3; i++) begin
      check("st_req", {mem_req, mem_we, done}, 3'b110);
      check("st_hold", {mem_addr, mem_wdata}, {16'h6000, 16'h1234});
      tick();
    end
    mem_ready = 1'b1;
    tick();
    check("st_done", {done, rf_we, err, mem_req}, 4'b1000);
    mem_ready = 1'b0;
    tick();

    // Timeout after 15 wait cycles
    accept(4'b0110, 0, 1, 0, 16'h6000, 16'h5555, 16'h0);
    for (int i = 0; i < 14; i++) tick();
    check("to_pending", {mem_req, done}, 2'b10);
    tick();
    check("to_fire", {done, err, rf_we, mem_req}, 4'b1100);
    tick();
    check("to_idle", {req_ready, done, err}, 3'b100);

    // mem_ready on the 15th wait cycle wins over timeout
    accept(4'b0110, 0, 1, 0, 16'h6002, 16'h6666, 16'h0);
    for (int i = 0; i < 14; i++) tick();
    mem_ready = 1'b1;
    tick();
    check("to_race", {done, err, rf_we}, 3'b100);
    mem_ready = 1'b0;
    tick();

    // Register op pass-through
    accept(4'b0000, 0, 0, 1, 16'h0, 16'h0, 16'h0007);
    check("add_done", {done, rf_we, err, mem_req}, 4'b1100);
    check("add_data", rf_wdata, 16'h0007);
    tick();

    // Illegal opcode and inconsistent flags
    accept(4'b1111, 0, 0, 1, 16'h0, 16'h0, 16'h1111);
    check("ill_op", {done, rf_we, err, mem_req}, 4'b1010);
    check("ill_nowb", rf_wdata, 16'h0007);
    tick();
    accept(4'b0011, 0, 1, 0, 16'h7000, 16'h0, 16'h0);
    check("ill_flags", {done, rf_we, err, mem_req}, 4'b1010);
    tick();

    // req_valid held high: accepts every other cycle
    alu_op = 4'b0001; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b1; alu_result = 16'h0042;
    req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("b2b_done", done, (i % 2 == 0) ? 1 : 0);
    end
    req_valid = 1'b0;
    tick();

    // Reset in the middle of an LDI wait
    mem_ready = 1'b0;
    accept(4'b0100, 1, 0, 1, 16'h4000, 16'h0, 16'h0);
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst", {mem_req, done, req_ready}, 3'b001);
    tick();
    rst = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h9999;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst", {done, mem_req, rf_we}, 3'b000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lc3_mem_access_unit.md
Name: lc3_mem_access_unit

Overview:
Execute/memory-stage sequencer that consumes the decoded control word (ALUOp, MemRead, MemWrite, RegWrite) and carries out the memory transaction it requests. LD performs one read, LDI performs two chained reads (pointer, then data), and ST performs one write. Register-only ops pass straight through. It sits between the opcode decoder and the data-memory port, and produces the register-file write strobe and write data.

Parameters:
DATA_W, 16, data and address width in bits.
TIMEOUT, 15, max cycles mem_req may wait for mem_ready before abort; 0 disables the timeout.
CNT_W, 4, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous active-high reset.
req_valid  in  1  control word valid.
req_ready  out  1  unit can accept a request (high only in IDLE).
alu_op  in  4  decoded ALUOp.
mem_read  in  1  decoder MemRead.
mem_write  in  1  decoder MemWrite.
reg_write  in  1  decoder RegWrite.
addr  in  DATA_W  effective address (LD/LDI/ST).
st_data  in  DATA_W  store data (ST).
alu_result  in  DATA_W  result for register-only ops.
mem_req  out  1  memory request, held until mem_ready.
mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
mem_addr  out  DATA_W  memory address; stable while mem_req is high.
mem_wdata  out  DATA_W  write data; stable while mem_req is high.
mem_rdata  in  DATA_W  read data, sampled when mem_req && mem_ready.
mem_ready  in  1  memory completes the access this cycle.
done  out  1  one-cycle completion pulse.
rf_we  out  1  register-file write strobe; only asserts in the done cycle.
rf_wdata  out  DATA_W  register write data; valid while done is high.
err  out  1  one-cycle pulse with done on timeout or illegal control word.

Behaviour:
- Reset (rst high at a clock edge, any state, including mid-transaction): state goes to IDLE and the timeout counter clears.
  - Reset values: req_ready=1; mem_req=0, mem_we=0, done=0, rf_we=0, err=0; mem_addr, mem_wdata and rf_wdata = 0.
  - An in-flight memory access is abandoned. mem_req drops in the cycle after the reset edge.
- Accept: a request is accepted when req_valid && req_ready at an edge. addr, st_data, alu_result, alu_op and the flags are registered then; later input changes are ignored.
- States: IDLE, RD1, RD2, WR, FIN.
- Dispatch from IDLE on accept:
  - alu_op=0011 with mem_read=1: go to RD1 (LD).
  - alu_op=0100 with mem_read=1: go to RD1, with the indirect flag set (LDI).
  - alu_op=0110 with mem_write=1: go to WR.
  - alu_op in {0000, 0001, 0010, 0101} with reg_write=1 and no memory flags: go to FIN with the write-back value = alu_result.
  - Anything else (including 1111, or flags inconsistent with alu_op): go to FIN with the error flag set and no write-back.
- RD1: mem_req=1, mem_we=0, mem_addr=latched addr.
  - On mem_ready, capture mem_rdata.
  - If indirect: go to RD2 with mem_addr = captured pointer.
  - Otherwise: go to FIN with write-back = captured data.
- RD2: mem_req=1, mem_we=0. On mem_ready, capture mem_rdata and go to FIN with write-back = data.
- WR: mem_req=1, mem_we=1, mem_wdata=latched st_data. On mem_ready, go to FIN with no write-back.
- FIN (exactly one cycle): done=1. rf_we=1 only for a successful load or register op. err=1 if the error flag is set. Then go to IDLE.
- mem_req drops in the cycle after mem_ready is sampled. Back-to-back chained reads (RD1→RD2) deassert mem_req for zero cycles; mem_addr changes at the same edge.
- Latency, accept edge to done high, with zero-wait memory (mem_ready already high):
  - Register op or illegal word: 1 cycle.
  - LD or ST: 2 cycles.
  - LDI: 3 cycles.
  - Each wait cycle adds 1.
- Timeout: the counter clears on entry to each of RD1/RD2/WR and increments every cycle mem_req is high and mem_ready is low. When it reaches TIMEOUT with mem_ready still low, go to FIN with err=1 and rf_we=0. mem_ready arriving in the same cycle takes priority over the timeout.
- req_ready=1 only in IDLE. A new request cannot be accepted during FIN, so the minimum spacing between accepts is 2 cycles.
- mem_ready while mem_req=0 is ignored.

Test Plan:
- Reset: assert rst for 2 cycles in the middle of an LDI wait → next cycle mem_req=0, done=0, req_ready=1; no done pulse afterwards.
- LD, zero-wait: accept alu_op=0011, mem_read=1, addr=0x3000, with mem_rdata=0xBEEF → mem_req with addr 0x3000 one cycle after accept; done=1, rf_we=1, rf_wdata=0xBEEF two cycles after accept.
- LDI with 2 wait states on each read: addr=0x4000; memory returns pointer 0x5123, then 0x00A5 → second read uses mem_addr=0x5123; done 7 cycles after accept with rf_wdata=0x00A5.
- ST: alu_op=0110, mem_write=1, addr=0x6000, st_data=0x1234, with mem_ready after 3 cycles → mem_we=1 and wdata held stable through the wait; done with rf_we=0.
- Timeout: ST with mem_ready held low and TIMEOUT=15 → done=err=1 on the cycle after 15 wait cycles, rf_we=0. Also: mem_ready arriving on the 15th wait cycle → err=0.
- Pass-through and illegal:
  - ADD (0000, reg_write=1), alu_result=0x0007 → done and rf_we one cycle after accept, rf_wdata=0x0007.
  - alu_op=1111 → done=err=1, rf_we=0, no mem_req.
  - req_valid held high continuously → accepts spaced exactly 2 cycles apart.
